fw_hazard_unit: RTL

Decode-side hazard and forwarding controller for the 5-stage core (IF/ID/EX/MEM/WB). It tracks the destination registers of in-flight instructions and compares them with the ID-stage sources. It registers a `fw_cntrl_bus_t` decision into EX, alongside the ID/EX pipeline register, and drives `bypass_bus_t` so the EX-stage forwarding mux can select operands. It also raises a one-cycle decode stall for load-use and split-source hazards, and counts stall cycles.

---
 rtl/fw_hazard_unit_pkg.sv | 43 ++++
 rtl/fw_hazard_unit_cmp.sv | 28 ++
 rtl/fw_hazard_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fw_hazard_unit_pkg.sv
// Shared types for the decode-side hazard/forwarding controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core;

  // Width of the bypass data bus carried in bypass_bus_t.
  localparam int CORE_XLEN = 32;

  typedef enum logic [1:0] {
    NONE_STAGE = 2'd0,
    MEM_STAGE  = 2'd1,
    WB_STAGE   = 2'd2
  } fw_stage_t;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS1     = 2'd1,
    RS2     = 2'd2,
    RS_BOTH = 2'd3
  } fw_regs_t;

  typedef struct packed {
    fw_stage_t stage;
    fw_regs_t  regs;
  } fw_cntrl_bus_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0] rd;
  } bypass_bus_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } hazard_slot_t;

  // A slot only produces a value worth forwarding if it really writes a non-x0 register.
  function automatic logic slot_is_producer(hazard_slot_t s);
    return s.valid && s.we && (s.rd != 5'd0);
  endfunction

endpackage

// File: rtl/fw_hazard_unit_cmp.sv
// Compares one ID source index against the EX and MEM shadow slots.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module hazard_cmp
  import core::*;
(
  input  logic [4:0]   rs,
  input  logic         use_rs,
  input  hazard_slot_t ex_slot,
  input  hazard_slot_t mem_slot,
  output logic         near_hit,
  output logic         far_hit,
  output logic         near_is_load
);

  logic src_live;

  // x0 and unread sources never create a dependency.
  assign src_live = use_rs && (rs != 5'd0);

  // Near hit takes precedence: the younger producer holds the value the consumer must see.
  always_comb begin
    near_hit     = src_live && slot_is_producer(ex_slot) && (ex_slot.rd == rs);
    far_hit      = src_live && slot_is_producer(mem_slot) && (mem_slot.rd == rs) && !near_hit;
    near_is_load = near_hit && ex_slot.is_load;
  end

endmodule

// File: rtl/fw_hazard_unit.sv
// Decode-side hazard detect, forwarding decision for EX, and stall counting.
// Latency: hazard_stall_o same cycle as ID inputs; fw_cntrl_o one cycle later (EX).
// Backpressure: stall_i freezes all state; hazard_stall_o holds IF/ID and bubbles ID/EX.
module fw_hazard_unit
  import core::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_we_i,
  input  logic            id_is_load_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic [XLEN-1:0] wb_result_i,
  output fw_cntrl_bus_t   fw_cntrl_o,
  output bypass_bus_t     bypass_o,
  output logic            hazard_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  hazard_slot_t  ex_slot;
  hazard_slot_t  mem_slot;
  hazard_slot_t  id_slot;
  fw_cntrl_bus_t decision;
  fw_cntrl_bus_t bubble_cntrl;

  logic rs1_near, rs1_far, rs1_near_load;
  logic rs2_near, rs2_far, rs2_near_load;
  logic rs1_hit, rs2_hit;
  logic load_use, split, issue;
  logic [XLEN-1:0] bypass_sel;

  hazard_cmp u_cmp_rs1 (
    .rs           (id_rs1_i),
    .use_rs       (id_use_rs1_i),
    .ex_slot      (ex_slot),
    .mem_slot     (mem_slot),
    .near_hit     (rs1_near),
    .far_hit      (rs1_far),
    .near_is_load (rs1_near_load)
  );

  hazard_cmp u_cmp_rs2 (
    .rs           (id_rs2_i),
    .use_rs       (id_use_rs2_i),
    .ex_slot      (ex_slot),
    .mem_slot     (mem_slot),
    .near_hit     (rs2_near),
    .far_hit      (rs2_far),
    .near_is_load (rs2_near_load)
  );

  assign rs1_hit      = rs1_near || rs1_far;
  assign rs2_hit      = rs2_near || rs2_far;
  assign bubble_cntrl = '{stage: NONE_STAGE, regs: RS_NONE};

  // Stall on load-use, or when the two sources need different bypass stages at once
  // (one mux cannot serve both; after one bubble the older producer is in the regfile).
  always_comb begin
    load_use       = rs1_near_load || rs2_near_load;
    split          = rs1_hit && rs2_hit && (rs1_near != rs2_near);
    hazard_stall_o = id_valid_i && !flush_i && (load_use || split);
    issue          = id_valid_i && !hazard_stall_o && !flush_i;
  end

  // Forwarding decision for the ID instruction; regs is RS_NONE exactly when nothing hits.
  always_comb begin
    decision = bubble_cntrl;
    if (rs1_near || rs2_near) begin
      decision.stage = MEM_STAGE;
    end else if (rs1_far || rs2_far) begin
      decision.stage = WB_STAGE;
    end
    unique case ({rs2_hit, rs1_hit})
      2'b01:   decision.regs = RS1;
      2'b10:   decision.regs = RS2;
      2'b11:   decision.regs = RS_BOTH;
      default: decision.regs = RS_NONE;
    endcase
  end

  // Shadow copy of the ID instruction as it would enter EX.
  always_comb begin
    id_slot         = '0;
    id_slot.valid   = 1'b1;
    id_slot.rd      = id_rd_i;
    id_slot.we      = id_we_i;
    id_slot.is_load = id_is_load_i;
  end

  // Advance the shadow slots and the EX-side decision in step with the pipeline.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_slot    <= '0;
      mem_slot   <= '0;
      fw_cntrl_o <= '{stage: NONE_STAGE, regs: RS_NONE};
    end else if (!stall_i) begin
      mem_slot   <= ex_slot;
      ex_slot    <= issue ? id_slot : '0;
      fw_cntrl_o <= issue ? decision : bubble_cntrl;
    end
  end

  // Count hazard stall cycles that actually take effect (not frozen, wraps naturally).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (hazard_stall_o && !stall_i) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  // Operand bypass select driven from the registered EX decision.
  always_comb begin
    bypass_sel = '0;
    unique case (fw_cntrl_o.stage)
      MEM_STAGE: bypass_sel = mem_result_i;
      WB_STAGE:  bypass_sel = wb_result_i;
      default:   bypass_sel = '0;
    endcase
    bypass_o.rd = CORE_XLEN'(bypass_sel);
  end

endmodule
